decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered, parametrised successor to the combinational `controller`: takes a full 32-bit RV32I instruction plus PC over a valid/ready handshake. It decodes opcode/func3/func7 into the same control-field set as `controller`, with optional M-extension and illegal-instruction detection. Results are buffered in a DEPTH-entry FIFO toward the execute stage. It sits between fetch and execute and supplies backpressure and flush.

## Interface
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- PC_W, 32: PC pass-through width.
- EN_M, 0: 1 = decode RV32M (func7=0000001 on opcode 0110011); 0 = such encodings are illegal.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  drop all buffered entries and the current input.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_pc  out  PC_W  head PC.
- MemWrite, MemRead, RegWrite  out  1 each  head control bits.
- ALUSrc  out  4  0 = rs2, 1 = imm, 2 = PC+imm, 3 = imm only.
- MemtoReg  out  4  0 = ALU, 1 = memory, 2 = PC+4.
- ALUControl  out  5  {is_mul, f7b5, func3}.
- BranchControl  out  4  0 = none, 1 = JAL, 2 = JALR, {1,func3} = conditional branch.
- Mem_mode  out  3  func3 for load/store, else 0.
- Mem_read_us  out  1  func3[2] for loads, else 0.
- illegal  out  1  head instruction undecodable.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Decode (combinational, on in_instr), then write into the FIFO on a push:
  - 0110011 R: RegWrite=1, ALUSrc=0, ALUControl={is_mul, f7[5], func3}.
    - Legal func7: 0000000; 0100000 only with func3 000 or 101; 0000001 only if EN_M (is_mul=1).
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ALUControl={0, f7[5]&(func3==101), func3}.
    - func3=001 needs func7=0. func3=101 needs func7 ∈ {0, 0100000}.
  - 0000011 load: MemRead=1, RegWrite=1, ALUSrc=1, MemtoReg=1, Mem_mode=func3, Mem_read_us=func3[2]. Legal func3 ∈ {000, 001, 010, 100, 101}.
  - 0100011 store: MemWrite=1, ALUSrc=1, Mem_mode=func3. Legal func3 ≤ 010.
  - 1100011 branch: BranchControl={1, func3}, ALUSrc=0. func3 010 and 011 are illegal.
  - 1101111 JAL: RegWrite=1, MemtoReg=2, BranchControl=1.
  - 1100111 JALR (func3=000 only): RegWrite=1, ALUSrc=1, MemtoReg=2, BranchControl=2.
  - 0110111 LUI: RegWrite=1, ALUSrc=3.
  - 0010111 AUIPC: RegWrite=1, ALUSrc=2.
  - Any other opcode, or an illegal case above: illegal=1 and every other control field 0. The entry is still enqueued so the trap logic sees its PC.
- Fields not listed for an opcode are 0.
- FIFO:
  - push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
  - in_ready = (count < DEPTH). It does not depend on out_ready, so there is no combinational ready path.
  - Push and pop in the same cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
- flush: next cycle count=0, out_valid=0, pointers=0. flush beats a simultaneous push and pop.
- out_* fields show the head entry; they may hold stale data when out_valid=0.

## Timing
- Reset (async assert, sync-to-clk release by the integrator):
  - count=0, out_valid=0, in_ready=1, pointers=0.
  - Every control output, out_pc and illegal are 0 (storage cleared).
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N, if the FIFO was empty.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Full (count=DEPTH): in_ready=0. A pop that cycle frees a slot visible next cycle.
- Empty: out_valid=0; out_ready is ignored.
- Reset asserted mid-stream: every entry is lost immediately, with no partial output.

## Test plan
- Reset, then push 0x00B50533 (add a0,a0,a1) with out_ready=1 -> next cycle out_valid=1, RegWrite=1, ALUSrc=0, ALUControl=0x00, illegal=0.
- Push each load 0x00052503 (lw), 0x00054503 (lbu), 0x00053503 (func3=011) -> Mem_mode=2/us=0, Mem_mode=4/us=1, then illegal=1 with MemRead=0.
- EN_M=0 vs 1, push 0x02B50533 (mul) -> illegal=1 vs ALUControl=0x10, RegWrite=1.
- DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready falls after the 2nd accept, count=2. Raise out_ready -> entries pop in order, matching PCs.
- Full FIFO with flush=1, in_valid=1, out_ready=1 simultaneously -> next cycle count=0, out_valid=0, and the offered instruction never appears.
- Push sw 0x00A52023, beq 0x00B50463, jal 0x008000EF, jalr 0x000500E7, lui 0x123452B7, auipc 0x00001517 -> MemWrite=1/Mem_mode=2; BranchControl=8; BranchControl=1/MemtoReg=2; BranchControl=2/ALUSrc=1; ALUSrc=3; ALUSrc=2.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I control decoder feeding a DEPTH-entry FIFO toward execute.
module decode_ctrl_pipe #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int EN_M  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic                     MemWrite,
    output logic                     MemRead,
    output logic                     RegWrite,
    output logic [3:0]               ALUSrc,
    output logic [3:0]               MemtoReg,
    output logic [4:0]               ALUControl,
    output logic [3:0]               BranchControl,
    output logic [2:0]               Mem_mode,
    output logic                     Mem_read_us,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + 25;
    logic [6:0] op, f7;
    logic [2:0] f3, mode;
    logic       legal, mw, mr, rw, us;
    logic [3:0] src, m2r, br;
    logic [4:0] alu;
    logic [EW-1:0] entry_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    always_comb begin
        legal = 1'b1;
        mw    = 1'b0;
        mr    = 1'b0;
        rw    = 1'b0;
        us    = 1'b0;
        src   = 4'd0;
        m2r   = 4'd0;
        br    = 4'd0;
        alu   = 5'd0;
        mode  = 3'd0;
        case (op)
            7'b0110011: begin
                legal = f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                        || (EN_M != 0 && f7 == 7'b0000001);
                rw    = 1'b1;
                alu   = {f7 == 7'b0000001, f7[5], f3};
            end
            7'b0010011: begin
                legal = f3 == 3'b001 ? f7 == 7'b0000000 :
                        f3 == 3'b101 ? (f7 == 7'b0000000 || f7 == 7'b0100000) : 1'b1;
                rw    = 1'b1;
                src   = 4'd1;
                alu   = {1'b0, f7[5] & (f3 == 3'b101), f3};
            end
            7'b0000011: begin
                legal = f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
                mr    = 1'b1;
                rw    = 1'b1;
                src   = 4'd1;
                m2r   = 4'd1;
                mode  = f3;
                us    = f3[2];
            end
            7'b0100011: begin
                legal = f3 <= 3'b010;
                mw    = 1'b1;
                src   = 4'd1;
                mode  = f3;
            end
            7'b1100011: begin
                legal = f3 != 3'b010 && f3 != 3'b011;
                br    = {1'b1, f3};
            end
            7'b1101111: begin
                rw  = 1'b1;
                m2r = 4'd2;
                br  = 4'd1;
            end
            7'b1100111: begin
                legal = f3 == 3'b000;
                rw    = 1'b1;
                src   = 4'd1;
                m2r   = 4'd2;
                br    = 4'd2;
            end
            7'b0110111: begin
                rw  = 1'b1;
                src = 4'd3;
            end
            7'b0010111: begin
                rw  = 1'b1;
                src = 4'd2;
            end
            default: legal = 1'b0;
        endcase
    end
    // Illegal encodings still enqueue with their PC so the trap logic can see them.
    assign entry_d = legal ? {in_pc, 1'b0, mw, mr, rw, src, m2r, alu, br, mode, us}
                           : {in_pc, 1'b1, 24'd0};
    assign in_ready  = count_q < (AW+1)'(DEPTH);
    assign out_valid = |count_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign count     = count_q;
    assign {out_pc, illegal, MemWrite, MemRead, RegWrite, ALUSrc, MemtoReg,
            ALUControl, BranchControl, Mem_mode, Mem_read_us} = mem_q[rd_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= entry_d;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: random and directed stimulus on EN_M=0 and EN_M=1 instances against a queue model.
module tb_decode_ctrl_pipe;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic       ill, mw, mr, rw;
        logic [3:0] src, m2r;
        logic [4:0] alu;
        logic [3:0] br;
        logic [2:0] mode;
        logic       us;
    } ctl_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic rdy0, ov0, mw0, mr0, rw0, il0, us0, rdy1, ov1, mw1, mr1, rw1, il1, us1;
    logic [3:0] src0, m2r0, br0, src1, m2r1, br1;
    logic [4:0] alu0, alu1;
    logic [2:0] mode0, mode1;
    logic [31:0] pc0, pc1;
    logic [CW-1:0] cnt0, cnt1;
    logic [24:0] got0, got1;
    int n_vec = 0, n_err = 0;
    ent_t q[$];
    always #5 clk = ~clk;
    decode_ctrl_pipe #(.DEPTH(DEPTH), .PC_W(32), .EN_M(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov0), .out_ready(out_ready),
        .out_pc(pc0), .MemWrite(mw0), .MemRead(mr0), .RegWrite(rw0), .ALUSrc(src0),
        .MemtoReg(m2r0), .ALUControl(alu0), .BranchControl(br0), .Mem_mode(mode0),
        .Mem_read_us(us0), .illegal(il0), .count(cnt0));
    decode_ctrl_pipe #(.DEPTH(DEPTH), .PC_W(32), .EN_M(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready),
        .out_pc(pc1), .MemWrite(mw1), .MemRead(mr1), .RegWrite(rw1), .ALUSrc(src1),
        .MemtoReg(m2r1), .ALUControl(alu1), .BranchControl(br1), .Mem_mode(mode1),
        .Mem_read_us(us1), .illegal(il1), .count(cnt1));
    assign got0 = {il0, mw0, mr0, rw0, src0, m2r0, alu0, br0, mode0, us0};
    assign got1 = {il1, mw1, mr1, rw1, src1, m2r1, alu1, br1, mode1, us1};
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic ctl_t ref_dec(input logic [31:0] i, input bit m);
        ctl_t c = '0;
        bit ok = 1'b1;
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        case (i[6:0])
            7'h33: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) || (f7 == 7'h01 && m);
                c.rw = 1; c.alu = {f7 == 7'h01, f7[5], f3};
            end
            7'h13: begin
                if (f3 == 3'd1) ok = f7 == 7'h00;
                if (f3 == 3'd5) ok = f7 inside {7'h00, 7'h20};
                c.rw = 1; c.src = 1; c.alu = {1'b0, f7[5] && f3 == 3'd5, f3};
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                c.mr = 1; c.rw = 1; c.src = 1; c.m2r = 1; c.mode = f3; c.us = f3[2];
            end
            7'h23: begin ok = f3 <= 3'd2; c.mw = 1; c.src = 1; c.mode = f3; end
            7'h63: begin ok = !(f3 inside {3'd2, 3'd3}); c.br = {1'b1, f3}; end
            7'h6F: begin c.rw = 1; c.m2r = 2; c.br = 1; end
            7'h67: begin ok = f3 == 3'd0; c.rw = 1; c.src = 1; c.m2r = 2; c.br = 2; end
            7'h37: begin c.rw = 1; c.src = 3; end
            7'h17: begin c.rw = 1; c.src = 2; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin c = '0; c.ill = 1'b1; end
        return c;
    endfunction
    function automatic ctl_t mk(input bit il, mw, mr, rw, input logic [3:0] src, m2r,
                                input logic [4:0] alu, input logic [3:0] br,
                                input logic [2:0] mode, input bit us);
        return '{il, mw, mr, rw, src, m2r, alu, br, mode, us};
    endfunction
    task automatic compare();
        check("count0", cnt0, q.size());
        check("count1", cnt1, q.size());
        check("in_ready0", rdy0, q.size() < DEPTH);
        check("in_ready1", rdy1, q.size() < DEPTH);
        check("out_valid0", ov0, q.size() != 0);
        check("out_valid1", ov1, q.size() != 0);
        if (q.size() != 0) begin
            check("ctl0", got0, ref_dec(q[0].instr, 1'b0));
            check("ctl1", got1, ref_dec(q[0].instr, 1'b1));
            check("pc0", pc0, q[0].pc);
            check("pc1", pc1, q[0].pc);
        end
    endtask
    task automatic step(input logic v, input logic [31:0] ins, pcv, input logic ordy, fl);
        bit push, pop;
        in_valid = v; in_instr = ins; in_pc = pcv; out_ready = ordy; flush = fl;
        push = v && q.size() < DEPTH && !fl;
        pop  = q.size() != 0 && ordy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{ins, pcv});
        end
        @(negedge clk);
        compare();
    endtask
    function automatic logic [31:0] rnd_instr();
        logic [31:0] i = $urandom;
        case ($urandom_range(0, 9))
            0: i[6:0] = 7'h33;
            1: i[6:0] = 7'h13;
            2: i[6:0] = 7'h03;
            3: i[6:0] = 7'h23;
            4: i[6:0] = 7'h63;
            5: i[6:0] = 7'h6F;
            6: i[6:0] = 7'h67;
            7: i[6:0] = 7'h37;
            8: i[6:0] = 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            2: i[31:25] = 7'h01;
            default: ;
        endcase
        return i;
    endfunction
    logic [31:0] d_ins [16] = '{32'h00B50533, 32'h00052503, 32'h00054503, 32'h00053503,
                                32'h02B50533, 32'h00A52023, 32'h00B50463, 32'h008000EF,
                                32'h000500E7, 32'h123452B7, 32'h00001517, 32'h40B50533,
                                32'h40355513, 32'hFFFFFFFF, 32'h00B52463, 32'h02051513};
    ctl_t d_e0 [16], d_e1 [16];
    initial begin
        d_e0[0]  = mk(0, 0, 0, 1, 0, 0, 5'h00, 0, 0, 0);
        d_e0[1]  = mk(0, 0, 1, 1, 1, 1, 5'h00, 0, 2, 0);
        d_e0[2]  = mk(0, 0, 1, 1, 1, 1, 5'h00, 0, 4, 1);
        d_e0[3]  = mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
        d_e0[4]  = mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
        d_e0[5]  = mk(0, 1, 0, 0, 1, 0, 5'h00, 0, 2, 0);
        d_e0[6]  = mk(0, 0, 0, 0, 0, 0, 5'h00, 8, 0, 0);
        d_e0[7]  = mk(0, 0, 0, 1, 0, 2, 5'h00, 1, 0, 0);
        d_e0[8]  = mk(0, 0, 0, 1, 1, 2, 5'h00, 2, 0, 0);
        d_e0[9]  = mk(0, 0, 0, 1, 3, 0, 5'h00, 0, 0, 0);
        d_e0[10] = mk(0, 0, 0, 1, 2, 0, 5'h00, 0, 0, 0);
        d_e0[11] = mk(0, 0, 0, 1, 0, 0, 5'h08, 0, 0, 0);
        d_e0[12] = mk(0, 0, 0, 1, 1, 0, 5'h0D, 0, 0, 0);
        d_e0[13] = mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
        d_e0[14] = mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
        d_e0[15] = mk(1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 0);
        d_e1 = d_e0;
        d_e1[4]  = mk(0, 0, 0, 1, 0, 0, 5'h10, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_count", cnt0, 0);
        check("rst_out_valid", ov0, 0);
        check("rst_in_ready", rdy0, 1);
        check("rst_ctl", got0, 0);
        check("rst_pc", pc0, 0);
        rst = 1'b0;
        @(negedge clk);
        compare();
        for (int i = 0; i < 16; i++) begin
            step(1, d_ins[i], 32'h1000 + 32'(4 * i), 1, 0);
            check("dir_ctl0", got0, d_e0[i]);
            check("dir_ctl1", got1, d_e1[i]);
            step(0, 0, 0, 1, 0);
        end
        for (int i = 0; i < 3; i++) step(1, d_ins[i], 32'h2000 + 32'(4 * i), 0, 0);
        check("full_count", cnt0, 2);
        check("full_in_ready", rdy0, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(1, d_ins[5 + i], 32'h3000 + 32'(4 * i), 0, 0);
        step(1, d_ins[7], 32'h3100, 1, 1);
        check("flush_count", cnt0, 0);
        check("flush_out_valid", ov0, 0);
        step(0, 0, 0, 1, 0);
        check("flush_dropped", ov0, 0);
        for (int i = 0; i < 2; i++) step(1, d_ins[9 + i], 32'h4000 + 32'(4 * i), 0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_count", cnt0, 0);
        check("arst_out_valid", ov0, 0);
        check("arst_ctl", got0, 0);
        check("arst_pc", pc1, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
